// File: rtl/ghr_checkpoint.sv
// Speculative global branch-history register with a per-branch checkpoint
// queue. Fetch shifts predictions in, out-of-order resolution repairs the
// history from the mispredicting branch's checkpoint, and in-order retirement
// builds the committed history that a full flush falls back to.
module ghr_checkpoint #(
    parameter int GHR_LEN    = 16,
    parameter int CKPT_DEPTH = 8,
    localparam int ID_W      = $clog2(CKPT_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_predict_valid,
    input  logic               i_predict_taken,
    output logic [ID_W-1:0]    o_ckpt_id,
    output logic               o_full,
    input  logic               i_resolve_valid,
    input  logic [ID_W-1:0]    i_resolve_id,
    input  logic               i_resolve_mispredict,
    input  logic               i_resolve_taken,
    input  logic               i_flush,
    output logic [GHR_LEN-1:0] o_ghr,
    output logic [GHR_LEN-1:0] o_committed_ghr
);

    localparam logic [ID_W:0] PTR_ONE = {{ID_W{1'b0}}, 1'b1};

    // Pointers carry a wrap bit above the slot index so full and empty differ.
    logic [ID_W:0]          head, tail;
    logic [ID_W-1:0]        head_slot, tail_slot;

    logic [GHR_LEN-1:0]     ckpt_q [CKPT_DEPTH];
    logic [CKPT_DEPTH-1:0]  dir_q, valid_q, res_q;

    logic                   res_ok, mispredict, pred_ok, retire;
    logic                   id_wrap;
    logic [ID_W:0]          mis_tail;
    logic [ID_W-1:0]        id_age;
    logic [CKPT_DEPTH-1:0]  squash;

    assign head_slot = head[ID_W-1:0];
    assign tail_slot = tail[ID_W-1:0];
    assign o_ckpt_id = tail_slot;
    assign o_full    = (head_slot == tail_slot) && (head[ID_W] != tail[ID_W]);

    // Qualify the incoming events; flush is applied on top in the register block.
    always_comb begin
        res_ok     = i_resolve_valid && valid_q[i_resolve_id];
        mispredict = res_ok && i_resolve_mispredict;
        pred_ok    = i_predict_valid && !o_full && !i_flush && !mispredict;
        // Retire looks only at state registered before this cycle.
        retire     = valid_q[head_slot] && res_q[head_slot];
        // A valid id lies in [head, tail): slots below head's slot sit one lap ahead.
        id_wrap    = (i_resolve_id >= head_slot) ? head[ID_W] : ~head[ID_W];
        mis_tail   = {id_wrap, i_resolve_id} + PTR_ONE;
        id_age     = i_resolve_id - head_slot;
    end

    // Entries strictly younger than the resolving branch (by age from head).
    always_comb begin
        logic [ID_W-1:0] age;
        squash = '0;
        age    = '0;
        for (int s = 0; s < CKPT_DEPTH; s++) begin
            age       = ID_W'(s) - head_slot;
            squash[s] = (age > id_age);
        end
    end

    // Queue, speculative and committed history state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head            <= '0;
            tail            <= '0;
            o_ghr           <= '0;
            o_committed_ghr <= '0;
            valid_q         <= '0;
            res_q           <= '0;
            dir_q           <= '0;
        end else if (i_flush) begin
            o_ghr   <= o_committed_ghr;
            tail    <= head;
            valid_q <= '0;
            res_q   <= '0;
        end else begin
            if (mispredict) begin
                o_ghr                <= {ckpt_q[i_resolve_id][GHR_LEN-2:0], i_resolve_taken};
                dir_q[i_resolve_id]  <= i_resolve_taken;
                tail                 <= mis_tail;
                valid_q              <= valid_q & ~squash;
                res_q                <= res_q & ~squash;
            end else if (pred_ok) begin
                ckpt_q[tail_slot]  <= o_ghr;
                dir_q[tail_slot]   <= i_predict_taken;
                valid_q[tail_slot] <= 1'b1;
                res_q[tail_slot]   <= 1'b0;
                o_ghr              <= {o_ghr[GHR_LEN-2:0], i_predict_taken};
                tail               <= tail + PTR_ONE;
            end
            if (res_ok) begin
                res_q[i_resolve_id] <= 1'b1;
            end
            // Later bit writes override the vector-wide squash above.
            if (retire) begin
                o_committed_ghr    <= {o_committed_ghr[GHR_LEN-2:0], dir_q[head_slot]};
                valid_q[head_slot] <= 1'b0;
                res_q[head_slot]   <= 1'b0;
                head               <= head + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ghr_checkpoint.sv
// Bench for ghr_checkpoint: directed scenarios plus randomized traffic, all
// checked each cycle against an age-ordered queue model of in-flight branches.
module tb_ghr_checkpoint;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_predict_valid, i_predict_taken;
    logic [2:0]  o_ckpt_id;
    logic        o_full;
    logic        i_resolve_valid, i_resolve_mispredict, i_resolve_taken;
    logic [2:0]  i_resolve_id;
    logic        i_flush;
    logic [15:0] o_ghr, o_committed_ghr;

    int checks = 0;
    int errors = 0;

    ghr_checkpoint #(.GHR_LEN(16), .CKPT_DEPTH(D)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_predict_valid      (i_predict_valid),
        .i_predict_taken      (i_predict_taken),
        .o_ckpt_id            (o_ckpt_id),
        .o_full               (o_full),
        .i_resolve_valid      (i_resolve_valid),
        .i_resolve_id         (i_resolve_id),
        .i_resolve_mispredict (i_resolve_mispredict),
        .i_resolve_taken      (i_resolve_taken),
        .i_flush              (i_flush),
        .o_ghr                (o_ghr),
        .o_committed_ghr      (o_committed_ghr)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight branches oldest-first, head as a running count.
    typedef struct {
        logic [15:0] ckpt;
        bit          dir;
        bit          res;
    } ent_t;

    ent_t        q[$];
    int          head_ctr;
    logic [15:0] m_ghr, m_cghr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        head_ctr = 0;
        m_ghr    = '0;
        m_cghr   = '0;
    endtask

    task automatic model_step(input bit pv, input bit pt, input bit rv, input int rid,
                              input bit rm, input bit rt, input bit fl);
        int k;
        bit ret, rdir, mis, was_full;
        if (fl) begin
            m_ghr = m_cghr;
            q.delete();
            return;
        end
        was_full = (q.size() == D);
        ret  = (q.size() > 0) && q[0].res;
        rdir = ret ? q[0].dir : 1'b0;
        k = -1;
        for (int i = 0; i < q.size(); i++)
            if ((head_ctr + i) % D == rid) k = i;
        mis = 1'b0;
        if (rv && k >= 0) begin
            q[k].res = 1'b1;
            if (rm) begin
                mis      = 1'b1;
                q[k].dir = rt;
                m_ghr    = {q[k].ckpt[14:0], rt};
                while (q.size() > k + 1) void'(q.pop_back());
            end
        end
        if (pv && !mis && !was_full) begin
            q.push_back('{ckpt: m_ghr, dir: pt, res: 1'b0});
            m_ghr = {m_ghr[14:0], pt};
        end
        if (ret) begin
            m_cghr = {m_cghr[14:0], rdir};
            void'(q.pop_front());
            head_ctr++;
        end
    endtask

    task automatic compare_all();
        chk("ghr",       32'(o_ghr),           32'(m_ghr));
        chk("cghr",      32'(o_committed_ghr), 32'(m_cghr));
        chk("full",      32'(o_full),          32'(q.size() == D));
        chk("ckpt_id",   32'(o_ckpt_id),       32'((head_ctr + q.size()) % D));
    endtask

    // One clock: drive inputs, advance model at the edge, compare just after.
    task automatic step(input bit pv, input bit pt, input bit rv, input int rid,
                        input bit rm, input bit rt, input bit fl);
        i_predict_valid      = pv;
        i_predict_taken      = pt;
        i_resolve_valid      = rv;
        i_resolve_id         = 3'(rid);
        i_resolve_mispredict = rm;
        i_resolve_taken      = rt;
        i_flush              = fl;
        @(posedge clk);
        model_step(pv, pt, rv, rid, rm, rt, fl);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pred(input bit t);
        step(1, t, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input int id, input bit mp, input bit t);
        step(0, 0, 1, id, mp, t, 0);
    endtask

    task automatic do_reset();
        rst                  = 1'b1;
        i_predict_valid      = 0;
        i_predict_taken      = 0;
        i_resolve_valid      = 0;
        i_resolve_id         = 0;
        i_resolve_mispredict = 0;
        i_resolve_taken      = 0;
        i_flush              = 0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        chk("rst_ghr",  32'(o_ghr),           0);
        chk("rst_cghr", 32'(o_committed_ghr), 0);
        chk("rst_full", 32'(o_full),          0);
        chk("rst_id",   32'(o_ckpt_id),       0);
    endtask

    initial begin
        do_reset();

        // T,T,N: ids 0,1,2 handed out, history 110.
        chk("id0", 32'(o_ckpt_id), 0);
        pred(1);
        chk("id1", 32'(o_ckpt_id), 1);
        pred(1);
        chk("id2", 32'(o_ckpt_id), 2);
        pred(0);
        chk("ghr_ttn", 32'(o_ghr), 32'h0006);

        // Mispredict id1 -> repair from its checkpoint, id2 squashed.
        resolve(1, 1, 0);
        chk("ghr_repair", 32'(o_ghr), 32'h0002);
        chk("tail_repair", 32'(o_ckpt_id), 2);
        resolve(2, 1, 1);
        chk("squashed_ignored", 32'(o_ghr), 32'h0002);

        // Fill the queue, drop the ninth predict, then retire to free a slot.
        do_reset();
        repeat (8) pred(1);
        chk("full_set", 32'(o_full), 1);
        pred(0);
        chk("full_drop", 32'(o_ghr), 32'h00FF);
        resolve(0, 0, 1);
        chk("full_hold", 32'(o_full), 1);
        idle();
        chk("full_clear", 32'(o_full), 0);
        chk("cghr_one", 32'(o_committed_ghr), 32'h1);

        // Out-of-order resolves retire in order.
        resolve(3, 0, 1);
        resolve(2, 0, 1);
        resolve(1, 0, 1);
        repeat (3) idle();
        chk("cghr_ooo", 32'(o_committed_ghr), 32'hF);

        // Predict and older mispredict in the same cycle: predict dropped.
        do_reset();
        pred(1); pred(1); pred(0);
        step(1, 1, 1, 0, 1, 0, 0);
        chk("mp_vs_pred_ghr", 32'(o_ghr), 32'h0000);
        chk("mp_vs_pred_tail", 32'(o_ckpt_id), 1);

        // Four predicts, two retire, then flush back to committed history.
        do_reset();
        pred(1); pred(0); pred(1); pred(1);
        resolve(0, 0, 1);
        resolve(1, 0, 0);
        idle();
        chk("pre_flush_cghr", 32'(o_committed_ghr), 32'h2);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("flush_ghr", 32'(o_ghr), 32'h2);
        chk("flush_id", 32'(o_ckpt_id), 2);
        chk("flush_full", 32'(o_full), 0);

        // Random traffic with wrap-around and one mid-run reset.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            bit pv, pt, rv, rm, rt, fl;
            int rid;
            if (n == 400) do_reset();
            pv  = ($urandom_range(0, 9) < 6);
            pt  = $urandom_range(0, 1);
            rv  = ($urandom_range(0, 9) < 5);
            rid = $urandom_range(0, D - 1);
            rm  = ($urandom_range(0, 3) == 0);
            rt  = $urandom_range(0, 1);
            fl  = ($urandom_range(0, 63) == 0);
            step(pv, pt, rv, rid, rm, rt, fl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
